axis_frame_packer: RTL and testbench

AXIS_FRAME_PACKER -- requirements
Module: axis_frame_packer

---
 rtl/axis_frame_packer.sv | 124 ++++++++++++
 tb/tb_axis_frame_packer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_packer.sv
// Packs a source word stream into fixed-length AXI-Stream frames for DMA S2MM, one frame per GPIO start edge.
// Buffer is first-word fall-through; optional per-frame header when PACKER_SEQ_HDR_EN is defined.
module axis_frame_packer #(
  parameter int DATA_W     = 32,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gpio_start,
  input  logic                  src_valid,
  input  logic [DATA_W-1:0]     src_data,
  output logic                  src_ready,
  output logic [DATA_W-1:0]     S_AXIS_tdata,
  output logic [DATA_W/8-1:0]   S_AXIS_tkeep,
  output logic                  S_AXIS_tlast,
  output logic                  S_AXIS_tvalid,
  input  logic                  S_AXIS_tready,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] FLEN     = 16'(FRAME_LEN);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_q;
  logic              start_evt;
  logic [15:0]       cnt_q;
  logic [15:0]       frame_cnt_q;
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              fifo_empty, fifo_full;
  logic [DATA_W:0]   head;
  logic              rd_en, last_rd;
  logic              wr_en;
  logic [DATA_W:0]   wr_word;

  // sync_q[1:0] is the synchronizer, sync_q[2] the edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], gpio_start};
  end
  assign start_evt = sync_q[1] & ~sync_q[2];

  assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
  assign fifo_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign S_AXIS_tvalid = !fifo_empty;
  assign S_AXIS_tdata  = fifo_empty ? '0 : head[DATA_W-1:0];
  assign S_AXIS_tlast  = !fifo_empty && head[DATA_W];
  assign S_AXIS_tkeep  = '1;
  assign rd_en         = S_AXIS_tvalid && S_AXIS_tready;
  assign last_rd       = rd_en && head[DATA_W];
  assign busy          = (state_q != IDLE);
  assign frame_cnt     = frame_cnt_q;

`ifdef PACKER_SEQ_HDR_EN
  logic              hdr_pend_q;
  logic [DATA_W-1:0] hdr_word;
  assign hdr_word = DATA_W'({16'hA5A5, frame_cnt_q});

  // Header goes out in the first RUN cycle; the buffer is guaranteed empty then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                hdr_pend_q <= 1'b0;
    else if (state_q == IDLE && start_evt)  hdr_pend_q <= 1'b1;
    else if (state_q == RUN)                hdr_pend_q <= 1'b0;
  end
`endif

  always_comb begin
    state_d   = state_q;
    src_ready = 1'b0;
    wr_en     = 1'b0;
    wr_word   = {1'b0, src_data};
    case (state_q)
      IDLE: if (start_evt) state_d = RUN;
      RUN: begin
`ifdef PACKER_SEQ_HDR_EN
        if (hdr_pend_q) begin
          wr_en   = 1'b1;
          wr_word = {1'b0, hdr_word};
        end else
`endif
        begin
          src_ready = !fifo_full && (cnt_q < FLEN);
          if (src_valid && src_ready) begin
            wr_en   = 1'b1;
            wr_word = {(cnt_q == LAST_IDX), src_data};
            if (cnt_q == LAST_IDX) state_d = DRAIN;
          end
        end
      end
      DRAIN: if (last_rd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE)           cnt_q <= '0;
      else if (src_valid && src_ready) cnt_q <= cnt_q + 16'd1;
      if (last_rd) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (wr_en)   wr_ptr_q    <= wr_ptr_q + PTR_ONE;
      if (rd_en)   rd_ptr_q    <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
  end

endmodule

// File: tb/tb_axis_frame_packer.sv
// Directed bench for axis_frame_packer (FRAME_LEN=8, FIFO_DEPTH=4); header expectations follow PACKER_SEQ_HDR_EN.
module tb_axis_frame_packer;
  localparam int DW = 32;
  localparam int FL = 8;
  localparam int FD = 4;
`ifdef PACKER_SEQ_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NB = FL + HDR;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          gpio_start = 1'b0;
  logic          src_valid = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic [DW-1:0] S_AXIS_tdata;
  logic [DW/8-1:0] S_AXIS_tkeep;
  logic          S_AXIS_tlast, S_AXIS_tvalid;
  logic          S_AXIS_tready = 1'b0;
  logic          busy;
  logic [15:0]   frame_cnt;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] q_dat[$];
  logic          q_last[$];
  logic [15:0]   exp_fc;

  axis_frame_packer #(.DATA_W(DW), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .gpio_start(gpio_start), .src_valid(src_valid),
    .src_data(src_data), .src_ready(src_ready), .S_AXIS_tdata(S_AXIS_tdata),
    .S_AXIS_tkeep(S_AXIS_tkeep), .S_AXIS_tlast(S_AXIS_tlast),
    .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // One clock: capture sink beats at negedge, advance the source word after an accept.
  task automatic cycle();
    bit acc;
    @(negedge clk);
    if (S_AXIS_tvalid && S_AXIS_tready) begin
      q_dat.push_back(S_AXIS_tdata);
      q_last.push_back(S_AXIS_tlast);
    end
    acc = src_valid && src_ready;
    @(posedge clk); #1;
    if (acc) src_data = src_data + 1;
  endtask

  task automatic pulse_start();
    gpio_start = 1'b1;
    repeat (3) cycle();
    gpio_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit done);
    bit seen;
    seen = busy;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
  endtask

  task automatic clear_q();
    q_dat.delete();
    q_last.delete();
    src_data = '0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL rst_src_ready got=%b want=0", src_ready); end
    total++; if (S_AXIS_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b want=0", S_AXIS_tvalid); end
    total++; if (S_AXIS_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b want=0", S_AXIS_tlast); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_frame_cnt got=%0d want=0", frame_cnt); end
    total++; if (S_AXIS_tdata !== '0) begin bad++; $display("FAIL rst_tdata got=%h want=0", S_AXIS_tdata); end
    total++; if (S_AXIS_tkeep !== 4'hF) begin bad++; $display("FAIL rst_tkeep got=%h want=f", S_AXIS_tkeep); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) cycle();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_idle busy=%b want=0", busy); end
    exp_fc = 16'd0;
  endtask

  task automatic test_basic();
    bit done;
    logic [DW-1:0] exp_d;
    clear_q();
    src_valid = 1'b1;
    S_AXIS_tready = 1'b1;
    pulse_start();
    wait_idle(100, done);
    total++; if (!done) begin bad++; $display("FAIL basic_timeout busy=%b want frame end", busy); end
    total++; if (q_dat.size() != NB) begin bad++; $display("FAIL basic_beats got=%0d want=%0d", q_dat.size(), NB); end
    for (int i = 0; i < q_dat.size() && i < NB; i++) begin
      exp_d = (HDR != 0 && i == 0) ? {16'hA5A5, exp_fc} : DW'(i - HDR);
      total++; if (q_dat[i] !== exp_d) begin bad++; $display("FAIL basic_data[%0d] got=%h want=%h", i, q_dat[i], exp_d); end
      total++; if (q_last[i] !== (i == NB-1)) begin bad++; $display("FAIL basic_last[%0d] got=%b want=%b", i, q_last[i], (i == NB-1)); end
    end
    exp_fc++;
    total++; if (frame_cnt !== exp_fc) begin bad++; $display("FAIL basic_frame_cnt got=%0d want=%0d", frame_cnt, exp_fc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", busy); end
  endtask

  task automatic test_backpressure();
    bit prev_stall, saw_full, seen, done, acc;
    logic [DW-1:0] prev_d, exp_d;
    logic prev_l;
    int acc_n, rd_n, occ;
    clear_q();
    prev_stall = 0; saw_full = 0; seen = 0; done = 0;
    prev_d = '0; prev_l = 0; acc_n = 0; rd_n = 0;
    src_valid = 1'b1;
    S_AXIS_tready = 1'b1;
    gpio_start = 1'b1;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc == 3) gpio_start = 1'b0;
      @(negedge clk);
      occ = acc_n + ((HDR != 0 && acc_n > 0) ? 1 : 0) - rd_n;
      if (prev_stall) begin
        total++;
        if (S_AXIS_tvalid !== 1'b1 || S_AXIS_tdata !== prev_d || S_AXIS_tlast !== prev_l) begin
          bad++; $display("FAIL bp_stable got v=%b d=%h l=%b want v=1 d=%h l=%b", S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, prev_d, prev_l);
        end
      end
      if (occ == FD) begin
        saw_full = 1'b1;
        total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0 occ=%0d", src_ready, occ); end
      end
      if (S_AXIS_tvalid && S_AXIS_tready) begin
        q_dat.push_back(S_AXIS_tdata); q_last.push_back(S_AXIS_tlast); rd_n++;
      end
      acc = src_valid && src_ready;
      if (acc) acc_n++;
      prev_stall = S_AXIS_tvalid && !S_AXIS_tready;
      prev_d = S_AXIS_tdata;
      prev_l = S_AXIS_tlast;
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
      if (!done) begin
        @(posedge clk); #1;
        if (acc) src_data = src_data + 1;
        S_AXIS_tready = ~S_AXIS_tready;
      end
    end
    S_AXIS_tready = 1'b1;
    total++; if (!done) begin bad++; $display("FAIL bp_timeout busy=%b want frame end", busy); end
    total++; if (!saw_full) begin bad++; $display("FAIL bp_fill got=no full state want=%0d buffered", FD); end
    total++; if (q_dat.size() != NB) begin bad++; $display("FAIL bp_beats got=%0d want=%0d", q_dat.size(), NB); end
    for (int i = 0; i < q_dat.size() && i < NB; i++) begin
      exp_d = (HDR != 0 && i == 0) ? {16'hA5A5, exp_fc} : DW'(i - HDR);
      total++; if (q_dat[i] !== exp_d) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", i, q_dat[i], exp_d); end
      total++; if (q_last[i] !== (i == NB-1)) begin bad++; $display("FAIL bp_last[%0d] got=%b want=%b", i, q_last[i], (i == NB-1)); end
    end
    exp_fc++;
    total++; if (frame_cnt !== exp_fc) begin bad++; $display("FAIL bp_frame_cnt got=%0d want=%0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_start_hold();
    bit done;
    logic [DW-1:0] exp_d;
    for (int f = 0; f < 2; f++) begin
      clear_q();
      S_AXIS_tready = 1'b1;
      if (f == 0) begin
        src_valid = 1'b0;
        gpio_start = 1'b1;
        repeat (100) cycle();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b want=1", busy); end
        total++; if (q_dat.size() != HDR) begin bad++; $display("FAIL hold_early_beats got=%0d want=%0d", q_dat.size(), HDR); end
        gpio_start = 1'b0;
        repeat (5) cycle();
        pulse_start();
        src_valid = 1'b1;
      end else begin
        pulse_start();
      end
      wait_idle(100, done);
      repeat (30) cycle();
      total++; if (!done) begin bad++; $display("FAIL hold_timeout[%0d] busy=%b want frame end", f, busy); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_extra_frame[%0d] busy=%b want=0", f, busy); end
      total++; if (q_dat.size() != NB) begin bad++; $display("FAIL hold_beats[%0d] got=%0d want=%0d", f, q_dat.size(), NB); end
      for (int i = 0; i < q_dat.size() && i < NB; i++) begin
        exp_d = (HDR != 0 && i == 0) ? {16'hA5A5, exp_fc} : DW'(i - HDR);
        total++; if (q_dat[i] !== exp_d) begin bad++; $display("FAIL hold_data[%0d] got=%h want=%h", i, q_dat[i], exp_d); end
      end
      exp_fc++;
      total++; if (frame_cnt !== exp_fc) begin bad++; $display("FAIL hold_frame_cnt[%0d] got=%0d want=%0d", f, frame_cnt, exp_fc); end
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    logic [DW-1:0] exp_d;
    clear_q();
    src_valid = 1'b1;
    S_AXIS_tready = 1'b1;
    pulse_start();
    for (int i = 0; i < 50 && src_data < 3; i++) cycle();
    total++; if (src_data !== 32'd3) begin bad++; $display("FAIL mid_accept got=%0d want=3 words", src_data); end
    rst = 1'b1;
    #1;
    total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL mid_src_ready got=%b want=0", src_ready); end
    total++; if (S_AXIS_tvalid !== 1'b0) begin bad++; $display("FAIL mid_tvalid got=%b want=0", S_AXIS_tvalid); end
    total++; if (S_AXIS_tdata !== '0) begin bad++; $display("FAIL mid_tdata got=%h want=0", S_AXIS_tdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL mid_frame_cnt got=%0d want=0", frame_cnt); end
    for (int i = 0; i < q_last.size(); i++) begin
      total++; if (q_last[i] !== 1'b0) begin bad++; $display("FAIL mid_partial_tlast[%0d] got=%b want=0", i, q_last[i]); end
    end
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_fc = 16'd0;
    repeat (3) cycle();
    clear_q();
    pulse_start();
    wait_idle(100, done);
    total++; if (!done) begin bad++; $display("FAIL mid_timeout busy=%b want frame end", busy); end
    total++; if (q_dat.size() != NB) begin bad++; $display("FAIL mid_beats got=%0d want=%0d", q_dat.size(), NB); end
    for (int i = 0; i < q_dat.size() && i < NB; i++) begin
      exp_d = (HDR != 0 && i == 0) ? {16'hA5A5, exp_fc} : DW'(i - HDR);
      total++; if (q_dat[i] !== exp_d) begin bad++; $display("FAIL mid_data[%0d] got=%h want=%h", i, q_dat[i], exp_d); end
    end
    exp_fc++;
    total++; if (frame_cnt !== exp_fc) begin bad++; $display("FAIL mid_frame_cnt_after got=%0d want=%0d", frame_cnt, exp_fc); end
  endtask

`ifdef PACKER_SEQ_HDR_EN
  task automatic test_header();
    bit done;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) cycle();
    exp_fc = 16'd0;
    for (int f = 0; f < 3; f++) begin
      clear_q();
      pulse_start();
      wait_idle(100, done);
      total++; if (!done) begin bad++; $display("FAIL hdr_timeout[%0d] busy=%b want frame end", f, busy); end
      total++; if (q_dat.size() != 9) begin bad++; $display("FAIL hdr_beats[%0d] got=%0d want=9", f, q_dat.size()); end
      if (q_dat.size() > 0) begin
        total++; if (q_dat[0] !== {16'hA5A5, exp_fc}) begin bad++; $display("FAIL hdr_word[%0d] got=%h want=%h", f, q_dat[0], {16'hA5A5, exp_fc}); end
      end
      exp_fc++;
    end
  endtask
`endif

  task automatic test_wrap();
    bit done;
    logic [DW-1:0] exp_d;
    force dut.frame_cnt_q = 16'hFFFF;
    cycle();
    release dut.frame_cnt_q;
    cycle();
    total++; if (frame_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h want=ffff", frame_cnt); end
    exp_fc = 16'hFFFF;
    clear_q();
    pulse_start();
    wait_idle(100, done);
    total++; if (!done) begin bad++; $display("FAIL wrap_timeout busy=%b want frame end", busy); end
    if (q_dat.size() > 0) begin
      exp_d = (HDR != 0) ? {16'hA5A5, exp_fc} : '0;
      total++; if (q_dat[0] !== exp_d) begin bad++; $display("FAIL wrap_first got=%h want=%h", q_dat[0], exp_d); end
    end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL wrap_frame_cnt got=%0d want=0", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_hold();
    test_reset_mid();
`ifdef PACKER_SEQ_HDR_EN
    test_header();
`endif
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=time limit want=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
